// File: rtl/bin2seg_pkg.sv
// Shared constants for the binary-to-7-segment converter: active-low segment
// codes in {g,f,e,d,c,b,a} order and the conversion FSM state encoding.
package bin2seg_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    SHIFT  = 2'd2,
    FORMAT = 2'd3
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;

  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

endpackage

// File: rtl/seg7_digit_decoder.sv
// One BCD digit to its active-low 7-segment code; non-decimal nibbles
// show as blank.
module seg7_digit_decoder
  import bin2seg_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    case (i_bcd)
      4'd0: o_seg = SEG_DIGIT[0];
      4'd1: o_seg = SEG_DIGIT[1];
      4'd2: o_seg = SEG_DIGIT[2];
      4'd3: o_seg = SEG_DIGIT[3];
      4'd4: o_seg = SEG_DIGIT[4];
      4'd5: o_seg = SEG_DIGIT[5];
      4'd6: o_seg = SEG_DIGIT[6];
      4'd7: o_seg = SEG_DIGIT[7];
      4'd8: o_seg = SEG_DIGIT[8];
      4'd9: o_seg = SEG_DIGIT[9];
      default: o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/bin2seg_seq_converter.sv
// Sequential binary-to-decimal 7-segment driver: double dabble, one input bit
// per clock, with optional leading-zero blanking, minus sign and overflow.
module bin2seg_seq_converter
  import bin2seg_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int DIGITS = 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      value,
  input  logic                  signed_mode,
  input  logic                  blank_lz,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [DIGITS*7-1:0]   seg,
  output logic [1:0]            dbg_state
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int IW = $clog2(DIGITS + 1);
  localparam int BW = 4 * DIGITS;

  // Handshake: start is taken only while busy=0 (IDLE); busy stays high from
  // the accepting edge until the edge that pulses done for one cycle, and
  // seg/overflow change only on that done edge.
  state_t              r_state, w_state_nxt;
  logic [WIDTH-1:0]    r_value;
  logic                r_signed, r_blank, r_neg, r_ovf;
  logic [WIDTH-1:0]    r_mag;
  logic [BW-1:0]       r_bcd;
  logic [CW-1:0]       r_cnt;
  logic [DIGITS*7-1:0] r_seg;
  logic                r_overflow, r_done;

  logic                w_neg;
  logic [WIDTH-1:0]    w_mag;
  logic [BW-1:0]       w_bcd_adj;
  logic [IW-1:0]       w_msd;
  logic                w_nib_bad, w_fmt_ovf;
  logic [DIGITS*7-1:0] w_img;
  logic [6:0]          w_dec [DIGITS];

  // The magnitude of the most negative word is 2^(WIDTH-1), which still fits
  // in WIDTH unsigned bits, so the WIDTH+1-bit negation's top bit is always 0.
  assign w_neg = r_signed & r_value[WIDTH-1];
  assign w_mag = w_neg ? (~r_value + 1'b1) : r_value;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = LOAD;
      LOAD:    w_state_nxt = SHIFT;
      SHIFT:   if (r_cnt == '0) w_state_nxt = FORMAT;
      FORMAT:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_bcd_adj = r_bcd;
    for (int k = 0; k < DIGITS; k++) begin
      if (r_bcd[4*k +: 4] >= 4'd5) w_bcd_adj[4*k +: 4] = r_bcd[4*k +: 4] + 4'd3;
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_dec
    seg7_digit_decoder u_dec (
      .i_bcd (r_bcd[4*g +: 4]),
      .o_seg (w_dec[g])
    );
  end

  // w_msd is the most significant nonzero digit (0 when the result is zero);
  // the sign, if any, takes the position just above it.
  always_comb begin
    w_msd     = '0;
    w_nib_bad = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (r_bcd[4*k +: 4] != 4'd0) w_msd = IW'(k);
      if (r_bcd[4*k +: 4] > 4'd9)  w_nib_bad = 1'b1;
    end
    w_fmt_ovf = r_ovf | w_nib_bad | (r_neg & (int'(w_msd) == DIGITS - 1));
    w_img = '1;
    for (int k = 0; k < DIGITS; k++) begin
      if (w_fmt_ovf)                           w_img[7*k +: 7] = SEG_MINUS;
      else if (r_neg && k == int'(w_msd) + 1)  w_img[7*k +: 7] = SEG_MINUS;
      else if (r_blank && k > int'(w_msd))     w_img[7*k +: 7] = SEG_BLANK;
      else                                     w_img[7*k +: 7] = w_dec[k];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_value    <= '0;
      r_signed   <= 1'b0;
      r_blank    <= 1'b0;
      r_neg      <= 1'b0;
      r_ovf      <= 1'b0;
      r_mag      <= '0;
      r_bcd      <= '0;
      r_cnt      <= '0;
      r_seg      <= '1;
      r_overflow <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_value  <= value;
            r_signed <= signed_mode;
            r_blank  <= blank_lz;
          end
        end
        LOAD: begin
          r_neg <= w_neg;
          r_mag <= w_mag;
          r_bcd <= '0;
          r_ovf <= 1'b0;
          r_cnt <= CW'(WIDTH - 1);
        end
        SHIFT: begin
          {r_bcd, r_mag} <= {w_bcd_adj[BW-2:0], r_mag, 1'b0};
          r_ovf          <= r_ovf | w_bcd_adj[BW-1];
          r_cnt          <= r_cnt - 1'b1;
        end
        FORMAT: begin
          r_seg      <= w_img;
          r_overflow <= w_fmt_ovf;
          r_done     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy      = (r_state != IDLE);
  assign done      = r_done;
  assign overflow  = r_overflow;
  assign seg       = r_seg;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_bin2seg_seq_converter.sv
// Self-checking bench for bin2seg_seq_converter: directed corner cases plus
// randomized conversions scored against an arithmetic decimal-display model.
module tb_bin2seg_seq_converter;

  localparam int W = 32;
  localparam int D = 8;
  localparam int EW = 7 * D + 1;

  logic           clock, reset_n, start, signed_mode, blank_lz;
  logic [W-1:0]   value;
  logic           busy, done, overflow;
  logic [7*D-1:0] seg;
  logic [1:0]     dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  int n_done   = 0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] mon_exp;

  bin2seg_seq_converter #(.WIDTH(W), .DIGITS(D)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .start       (start),
    .value       (value),
    .signed_mode (signed_mode),
    .blank_lz    (blank_lz),
    .busy        (busy),
    .done        (done),
    .overflow    (overflow),
    .seg         (seg),
    .dbg_state   (dbg_state)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: decimal digits of the magnitude, sign just above the top digit.
  function automatic logic [EW-1:0] model(input logic [W-1:0] v, input bit sm, input bit bl);
    logic [6:0] code [10];
    longint unsigned m, t, lim;
    bit neg, ov;
    int nd;
    logic [7*D-1:0] s;
    code = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
             7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    neg = sm && v[W-1];
    m = longint'(v) & ((64'd1 << W) - 1);
    if (neg) m = (64'd1 << W) - m;
    lim = 1;
    for (int i = 0; i < D; i++) lim = lim * 10;
    nd = 0;
    t = m;
    do begin t = t / 10; nd++; end while (t > 0);
    ov = (m >= lim) || (neg && nd >= D);
    t = m;
    for (int k = 0; k < D; k++) begin
      if (ov)                  s[7*k +: 7] = 7'b0111111;
      else if (k < nd)         s[7*k +: 7] = code[int'(t % 10)];
      else if (neg && k == nd) s[7*k +: 7] = 7'b0111111;
      else if (bl)             s[7*k +: 7] = 7'b1111111;
      else                     s[7*k +: 7] = code[0];
      t = t / 10;
    end
    return {ov, s};
  endfunction

  // scoreboard: every done pops one expected image
  always @(posedge clock) begin
    #1;
    if (done) begin
      n_done++;
      if (exp_q.size() == 0) check("unexpected_done", 64'd1, 64'd0);
      else begin
        mon_exp = exp_q.pop_front();
        check("seg", 64'(seg), 64'(mon_exp[7*D-1:0]));
        check("overflow", 64'(overflow), 64'(mon_exp[7*D]));
      end
    end
  end

  // driver: called between edges with busy=0; returns #1 after accepting edge
  task automatic start_conv(input logic [W-1:0] v, input bit sm, input bit bl);
    value = v; signed_mode = sm; blank_lz = bl; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    value = W'($urandom); signed_mode = 1'($urandom); blank_lz = 1'($urandom);
    check("busy_after_accept", 64'(busy), 64'd1);
    exp_q.push_back(model(v, sm, bl));
  endtask

  task automatic wait_done(input string tag, input int elapsed);
    int n;
    n = elapsed;
    while (!done && n < W + 12) begin
      @(posedge clock); #1; n++;
    end
    check({tag, "_latency"}, 64'(n), 64'(W + 2));
    check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
  endtask

  task automatic run_conv(input string tag, input logic [W-1:0] v, input bit sm, input bit bl);
    @(negedge clock);
    start_conv(v, sm, bl);
    wait_done(tag, 0);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    int d0;
    logic [W-1:0] rv;
    int mode;
    reset_n = 1'b0; start = 1'b0; value = '0; signed_mode = 1'b0; blank_lz = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_seg", 64'(seg), 64'({7*D{1'b1}}));
    @(negedge clock); reset_n = 1'b1;
    idle_cycles(2);

    run_conv("u12345678", 32'd12345678, 1'b0, 1'b0);
    check("u12345678_lit", 64'(seg), 64'({7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                          7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000}));
    run_conv("zero_blank", 32'd0, 1'b0, 1'b1);
    run_conv("seven", 32'd7, 1'b0, 1'b0);
    run_conv("neg42", 32'hFFFFFFD6, 1'b1, 1'b1);
    check("neg42_lit", 64'(seg), 64'({{5{7'b1111111}}, 7'b0111111, 7'b0011001, 7'b0100100}));
    run_conv("neg42_nobl", 32'hFFFFFFD6, 1'b1, 1'b0);
    run_conv("most_neg", 32'h80000000, 1'b1, 1'b0);
    check("most_neg_ovf", 64'(overflow), 64'd1);
    run_conv("u1e8", 32'd100000000, 1'b0, 1'b1);
    run_conv("u99999999", 32'd99999999, 1'b0, 1'b1);
    run_conv("neg1e7", -32'sd10000000, 1'b1, 1'b1);
    run_conv("neg9999999", -32'sd9999999, 1'b1, 1'b1);
    run_conv("umax", 32'hFFFFFFFF, 1'b0, 1'b0);
    run_conv("sminus1", 32'hFFFFFFFF, 1'b1, 1'b1);

    // start during busy is dropped
    d0 = n_done;
    @(negedge clock);
    start_conv(32'd31415, 1'b0, 1'b1);
    idle_cycles(4);
    start = 1'b1; value = 32'd999; signed_mode = 1'b0; blank_lz = 1'b0;
    @(posedge clock); #1;
    start = 1'b0;
    check("ignore_busy_held", 64'(busy), 64'd1);
    wait_done("ignore", 5);
    idle_cycles(W + 8);
    check("ignore_one_done", 64'(n_done - d0), 64'd1);

    // back-to-back: start in the done cycle
    run_conv("b2b_first", 32'd2024, 1'b0, 1'b1);
    start_conv(-32'sd77, 1'b1, 1'b1);
    wait_done("b2b_second", 0);

    // reset mid-conversion aborts without done
    idle_cycles(1);
    d0 = n_done;
    @(negedge clock);
    start_conv(32'd55555, 1'b0, 1'b0);
    idle_cycles(9);
    #2 reset_n = 1'b0;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_seg", 64'(seg), 64'({7*D{1'b1}}));
    check("abort_done", 64'(done), 64'd0);
    exp_q.delete();
    idle_cycles(2);
    @(negedge clock); reset_n = 1'b1;
    idle_cycles(W + 6);
    check("abort_no_done", 64'(n_done - d0), 64'd0);
    run_conv("after_abort", 32'd4321, 1'b0, 1'b1);

    // randomized
    for (int i = 0; i < 40; i++) begin
      mode = $urandom_range(0, 3);
      case (mode)
        0:       rv = W'($urandom);
        1:       rv = W'($urandom_range(0, 99999));
        2:       rv = -W'($urandom_range(1, 12000000));
        default: rv = W'($urandom);
      endcase
      run_conv("rand", rv, (mode >= 2), 1'($urandom));
      if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 3));
    end

    idle_cycles(3);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bin2seg_seq_converter.md
Name: bin2seg_seq_converter

Overview:
Parametrised sequential binary-to-7-segment display driver for the board display bank. It converts an unsigned or two's-complement word into DIGITS decimal digits using shift-add-3 (double dabble), one input bit per clock. Leading-zero blanking, a minus sign and overflow indication are optional per conversion. It sits between the datapath debug/register tap and the HEX display pins, and holds a stable image between conversions.

Parameters:
WIDTH, 32, input word width in bits (>=4)
DIGITS, 8, number of 7-segment digits driven (1..10)

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
start  in  1  request conversion of value; accepted only when busy=0
value  in  WIDTH  binary input, sampled on the accepting edge
signed_mode  in  1  1: value is two's complement; sampled with value
blank_lz  in  1  1: blank leading zeros; sampled with value
busy  out  1  conversion in progress
done  out  1  one-cycle pulse; seg/overflow updated on the same edge
overflow  out  1  last result did not fit in DIGITS positions
seg  out  DIGITS*7  digit k in seg[7k+6:7k], k=0 least significant; active-low, bit order {g,f,e,d,c,b,a}

Behaviour:
- Reset (async, reset_n=0): state IDLE, busy=0, done=0, overflow=0, seg all 1s (blank), internal registers 0.
- Segment codes: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, blank=1111111, minus=0111111.
- FSM: IDLE -> LOAD -> SHIFT (WIDTH cycles) -> FORMAT -> IDLE.
- IDLE: start=1 latches value/signed_mode/blank_lz; busy=1 from the next edge.
- LOAD: magnitude = (signed_mode and value[WIDTH-1]) ? -value : value, computed WIDTH+1 bits wide so the most negative value converts correctly; neg flag latched; BCD register (4*DIGITS bits) cleared; sticky ovf cleared.
- SHIFT: each cycle add 3 to every BCD nibble >=5, then shift {bcd,mag} left by 1; a 1 shifted out of the top nibble sets sticky ovf. Counter from WIDTH-1 down to 0.
- FORMAT: build the new image. If ovf, every digit = minus. Else decode each nibble. If blank_lz, blank digits above the most significant nonzero digit; digit 0 is always shown. If neg: minus goes in the first blank position left of the number; if no position is free, the result is overflow (all minus).
- seg, overflow and done=1 are registered on the edge leaving FORMAT; busy=0 on that same edge.
- Latency: done rises exactly WIDTH+2 edges after the edge that accepted start.
- seg and overflow hold their value until the next done; there are no intermediate glitches on outputs.
- start while busy=1 is ignored (not queued). start in the cycle done=1 is accepted, so back-to-back conversions are allowed.
- reset_n low mid-conversion aborts immediately to reset values; no done is issued.
- The nibble correction can never exceed 9 after the final shift; any nibble >9 is an ovf case.

Decomposition:
- Package bin2seg_pkg: segment constants (SEG_BLANK, SEG_MINUS, SEG_DIGIT[0:9]), FSM state typedef (IDLE, LOAD, SHIFT, FORMAT).
- Sub-module seg7_digit_decoder: combinational 4-bit BCD -> 7-bit active-low code; values 10..15 decode to blank. Instantiated DIGITS times in FORMAT.

Test Plan:
- WIDTH=32, DIGITS=8, value=12345678, unsigned, blank_lz=0 -> done after 34 edges; digits7..0 = 1,2,3,4,5,6,7,8; overflow=0.
- value=0, blank_lz=1 -> digit0=1000000, digits7..1=1111111; value=7, blank_lz=0 -> digit0=1111000, others 1000000.
- value=-42 (32'hFFFFFFD6), signed_mode=1, blank_lz=1 -> digit2=0111111, digit1=0011001, digit0=0100100, rest blank. value=32'h80000000 signed -> overflow=1, all 0111111.
- value=100000000 unsigned -> overflow=1, all digits 0111111. Signed -10000000 with DIGITS=8 -> overflow (no free sign position).
- start pulsed again at cycle 5 of a busy conversion -> ignored; one done only. start asserted in the done cycle -> second done exactly 34 edges later.
- reset_n low at cycle 10 of a conversion -> busy=0, seg all 1s immediately; no done. Release, then new start -> normal result.
